// File: rtl/tmec_decode_serial_ctrl.sv
// Sequencer for the serial inversionless Berlekamp-Massey datapath: strobes each
// M+1-cycle iteration, tracks locator degree L and reports done/uncorrectable.
module tmec_decode_serial_ctrl #(
  parameter int M = 4,
  parameter int T = 3,
  localparam int LW = (2*T > 2) ? $clog2(2*T) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          drnzero,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] err_deg,
  output logic          uncorrectable,
  output logic          synpe,
  output logic          snce,
  output logic          bsel,
  output logic          caLast,
  output logic          cbBeg,
  output logic          msmpe,
  output logic          cce,
  output logic          dringPe,
  output logic          c0first
);
  localparam int PW = $clog2(M+1);
  localparam int KW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q;
  logic [KW-1:0] k_q;
  logic [LW-1:0] l_q, k_ext, l_upd;
  logic          bsel_q, unc_q, ph_last, k_last, bsel_n;

  assign ph_last = (ph_q == PW'(M));
  assign k_last  = (k_q == KW'(T-1));
  assign k_ext   = LW'(k_q);
  // bsel_q is the length-change decision for the current iteration; it was
  // formed from the discrepancy presented at LOAD or at the previous caLast.
  assign l_upd   = bsel_q ? ((k_ext << 1) + LW'(1) - l_q) : l_q;
  assign bsel_n  = drnzero && (l_upd <= k_ext + LW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      k_q     <= '0;
      l_q     <= '0;
      bsel_q  <= 1'b0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          ph_q   <= '0;
          k_q    <= '0;
          l_q    <= '0;
          unc_q  <= 1'b0;
          bsel_q <= drnzero;
        end
        ITER: begin
          if (ph_last) begin
            ph_q <= '0;
            l_q  <= l_upd;
            if (k_last) begin
              k_q    <= '0;
              bsel_q <= 1'b0;
              unc_q  <= (l_upd > LW'(T));
            end else begin
              k_q    <= k_q + KW'(1);
              bsel_q <= bsel_n;
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    synpe   = 1'b0;
    snce    = 1'b0;
    caLast  = 1'b0;
    cbBeg   = 1'b0;
    msmpe   = 1'b0;
    cce     = 1'b0;
    dringPe = 1'b0;
    c0first = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        synpe   = 1'b1;
        snce    = 1'b1;
        state_d = ITER;
      end
      ITER: begin
        busy    = 1'b1;
        msmpe   = (ph_q == '0);
        dringPe = (ph_q == '0);
        snce    = (ph_q == '0);
        cce     = (ph_q != '0);
        caLast  = ph_last;
        cbBeg   = (k_q == '0);
        c0first = (k_q == '0);
        if (ph_last && k_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bsel          = bsel_q;
  assign err_deg       = l_q;
  assign uncorrectable = unc_q;
endmodule

// File: tb/tb_tmec_decode_serial_ctrl.sv
// Directed bench for tmec_decode_serial_ctrl: per-cycle strobe traces compared
// against hand-derived bit masks, plus a small BM degree model for T=2.
module tb_tmec_decode_serial_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: M=4, T=3
  logic a_rst = 1'b1, a_start = 1'b0, a_dz = 1'b0;
  logic a_ready, a_busy, a_done, a_unc, a_synpe, a_snce, a_bsel, a_calast;
  logic a_cbbeg, a_msmpe, a_cce, a_dringpe, a_c0first;
  logic [2:0] a_deg;
  // DUT b: M=4, T=2
  logic b_rst = 1'b1, b_start = 1'b0, b_dz = 1'b0;
  logic b_ready, b_busy, b_done, b_unc, b_synpe, b_snce, b_bsel, b_calast;
  logic b_cbbeg, b_msmpe, b_cce, b_dringpe, b_c0first;
  logic [1:0] b_deg;

  tmec_decode_serial_ctrl #(.M(4), .T(3)) dut_a (
    .clk(clk), .reset(a_rst), .start(a_start), .drnzero(a_dz),
    .ready(a_ready), .busy(a_busy), .done(a_done), .err_deg(a_deg),
    .uncorrectable(a_unc), .synpe(a_synpe), .snce(a_snce), .bsel(a_bsel),
    .caLast(a_calast), .cbBeg(a_cbbeg), .msmpe(a_msmpe), .cce(a_cce),
    .dringPe(a_dringpe), .c0first(a_c0first));

  tmec_decode_serial_ctrl #(.M(4), .T(2)) dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .drnzero(b_dz),
    .ready(b_ready), .busy(b_busy), .done(b_done), .err_deg(b_deg),
    .uncorrectable(b_unc), .synpe(b_synpe), .snce(b_snce), .bsel(b_bsel),
    .caLast(b_calast), .cbBeg(b_cbbeg), .msmpe(b_msmpe), .cce(b_cce),
    .dringPe(b_dringpe), .c0first(b_c0first));

  // bundle bit indices
  localparam int C0F = 0, DRP = 1, CCE = 2, MSM = 3, CBB = 4, CAL = 5, BSL = 6,
                 SNC = 7, SYN = 8, UNC = 9, DON = 10, BSY = 11, RDY = 12;
  logic [12:0] oa, ob;
  assign oa = {a_ready, a_busy, a_done, a_unc, a_synpe, a_snce, a_bsel, a_calast,
               a_cbbeg, a_msmpe, a_cce, a_dringpe, a_c0first};
  assign ob = {b_ready, b_busy, b_done, b_unc, b_synpe, b_snce, b_bsel, b_calast,
               b_cbbeg, b_msmpe, b_cce, b_dringpe, b_c0first};

  logic [63:0] rec [13];
  int deg [64];
  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive n cycles (cycle c = period after the c-th edge) and record outputs.
  task automatic run(input bit sel, input logic [63:0] stm, input logic [63:0] dzm,
                     input logic [63:0] rstm, input int n);
    for (int i = 0; i < 13; i++) rec[i] = '0;
    for (int c = 0; c < n; c++) begin
      if (sel) begin b_start = stm[c]; b_dz = dzm[c]; b_rst = rstm[c]; end
      else     begin a_start = stm[c]; a_dz = dzm[c]; a_rst = rstm[c]; end
      for (int i = 0; i < 13; i++) rec[i][c] = sel ? ob[i] : oa[i];
      deg[c] = sel ? int'(b_deg) : int'(a_deg);
      @(posedge clk); #1;
    end
    a_start = 1'b0; a_dz = 1'b0; a_rst = 1'b0;
    b_start = 1'b0; b_dz = 1'b0; b_rst = 1'b0;
  endtask

  // Textbook BM length recursion, T=2; delta_k presented at LOAD (cycle 1)
  // for k=0 and at caLast of iteration k-1 (cycle 6+5(k-1)) otherwise.
  function automatic int bm_model(input logic [63:0] dz);
    int L = 0;
    logic d;
    d = dz[1];
    for (int k = 0; k < 2; k++) begin
      if (d && (L <= k)) L = 2*k + 1 - L;
      d = dz[6 + 5*k];
    end
    return L;
  endfunction

  logic [63:0] r;
  logic [8:0] stb10;
  int exp_l;

  initial begin
    @(posedge clk); @(posedge clk); #1;
    chk("rst_bundle_a", 64'(oa), 64'h1000);
    chk("rst_deg_a", 64'(a_deg), 64'd0);
    chk("rst_bundle_b", 64'(ob), 64'h1000);
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;

    // drnzero=0 throughout
    run(1'b0, 64'h1, 64'h0, 64'h0, 20);
    chk("t1_synpe",  rec[SYN], 64'h2);
    chk("t1_msmpe",  rec[MSM], 64'h1084);
    chk("t1_dringpe",rec[DRP], 64'h1084);
    chk("t1_snce",   rec[SNC], 64'h1086);
    chk("t1_calast", rec[CAL], 64'h10840);
    chk("t1_cce",    rec[CCE], 64'h1EF78);
    chk("t1_cbbeg",  rec[CBB], 64'h7C);
    chk("t1_c0first",rec[C0F], 64'h7C);
    chk("t1_done",   rec[DON], 64'h20000);
    chk("t1_busy",   rec[BSY], 64'h1FFFE);
    chk("t1_ready",  rec[RDY], 64'hC0001);
    chk("t1_bsel",   rec[BSL], 64'h0);
    chk("t1_deg",    64'(deg[17]), 64'd0);
    chk("t1_unc",    rec[UNC], 64'h0);

    // drnzero=1 only at LOAD
    run(1'b0, 64'h1, 64'h2, 64'h0, 20);
    chk("t2_bsel",   rec[BSL], 64'h7C);
    chk("t2_deg6",   64'(deg[6]), 64'd0);
    chk("t2_deg7",   64'(deg[7]), 64'd1);
    chk("t2_deg17",  64'(deg[17]), 64'd1);
    chk("t2_unc",    64'(rec[UNC][17]), 64'd0);

    // drnzero=1 at every sample: L 0->1->2->3
    run(1'b0, 64'h1, '1, 64'h0, 20);
    chk("t3_bsel",   rec[BSL], 64'h1FFFC);
    chk("t3_deg7",   64'(deg[7]), 64'd1);
    chk("t3_deg12",  64'(deg[12]), 64'd2);
    chk("t3_deg17",  64'(deg[17]), 64'd3);
    chk("t3_deg19",  64'(deg[19]), 64'd3);
    chk("t3_unc",    64'(rec[UNC][17]), 64'd0);

    // T=2: drnzero 0 at LOAD, 1 at caLast k=0 -> L=3 > T
    run(1'b1, 64'h1, 64'h40, 64'h0, 14);
    chk("t4_done",   rec[DON], 64'h1000);
    chk("t4_bsel",   rec[BSL], 64'hF80);
    chk("t4_deg",    64'(deg[12]), 64'd3);
    chk("t4_unc12",  64'(rec[UNC][12]), 64'd1);
    chk("t4_unc13",  64'(rec[UNC][13]), 64'd1);
    // T=2 all ones: L=2, not uncorrectable; flag from previous decode cleared
    run(1'b1, 64'h1, '1, 64'h0, 14);
    chk("t4b_unc0",  64'(rec[UNC][0]), 64'd1);
    chk("t4b_deg",   64'(deg[12]), 64'd2);
    chk("t4b_unc12", 64'(rec[UNC][12]), 64'd0);

    // T=2 random drnzero streams against the BM model
    for (int s = 0; s < 40; s++) begin
      r = {$urandom, $urandom};
      exp_l = bm_model(r);
      run(1'b1, 64'h1, r, 64'h0, 14);
      chk("rnd_deg", 64'(deg[12]), 64'(exp_l));
      chk("rnd_unc", 64'(rec[UNC][12]), 64'(exp_l > 2));
    end

    // reset at cycle 9 mid iteration 1, restart at cycle 10
    run(1'b0, 64'h401, '1, 64'h200, 30);
    for (int i = 0; i < 9; i++) stb10[i] = rec[i][10];
    chk("t5_deg9",   64'(deg[9]), 64'd1);
    chk("t5_ready10",64'(rec[RDY][10]), 64'd1);
    chk("t5_stb10",  64'(stb10), 64'h0);
    chk("t5_deg10",  64'(deg[10]), 64'd0);
    chk("t5_done",   rec[DON], 64'h8000000);
    chk("t5_deg27",  64'(deg[27]), 64'd3);

    // start coincident with reset: no LOAD
    run(1'b0, 64'h1, 64'h0, 64'h1, 4);
    chk("t6_synpe",  rec[SYN], 64'h0);
    chk("t6_ready",  rec[RDY], 64'hF);

    // start at 0, 5, 17 (DONE) and 18
    run(1'b0, 64'h60021, 64'h0, 64'h0, 38);
    chk("t7_done",   rec[DON], (64'h1 << 17) | (64'h1 << 35));
    chk("t7_synpe",  rec[SYN], (64'h1 << 1) | (64'h1 << 19));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
